// File: rtl/sm83_fetch_pkg.sv
// sm83_fetch_pkg: state encodings and length classes shared by the
// SM83 fetch sequencer and the control FSM.
package sm83_fetch_pkg;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH_OP,
        S_FETCH_IMM,
        S_HOLD,
        S_ERR
    } fetch_state_t;

    localparam logic [7:0] OP_CB_PREFIX = 8'hCB;

    localparam logic [1:0] LEN_0 = 2'd0;
    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;

endpackage

// File: rtl/sm83_oplen_decode.sv
// sm83_oplen_decode: opcode -> immediate byte count and CB-prefix flag.
// FETCH_CB_PREFIX_EN: 0xCB carries its extended opcode as one immediate.
module sm83_oplen_decode
    import sm83_fetch_pkg::*;
(
    input  logic [7:0] op,
    output logic [1:0] len,
    output logic       is_cb
);

    always_comb begin
        len   = LEN_0;
        is_cb = 1'b0;
        unique case (op)
            8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
            8'h18, 8'h20, 8'h28, 8'h30, 8'h38,
            8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE0, 8'hE6, 8'hE8,
            8'hEE, 8'hF0, 8'hF6, 8'hF8, 8'hFE:
                len = LEN_1;
            8'h01, 8'h08, 8'h11, 8'h21, 8'h31,
            8'hC2, 8'hC3, 8'hC4, 8'hCA, 8'hCC, 8'hCD,
            8'hD2, 8'hD4, 8'hDA, 8'hDC, 8'hEA, 8'hFA:
                len = LEN_2;
`ifdef FETCH_CB_PREFIX_EN
            OP_CB_PREFIX: begin
                len   = LEN_1;
                is_cb = 1'b1;
            end
`endif
            default: len = LEN_0;
        endcase
    end

endmodule

// File: rtl/sm83_fetch_seq.sv
// sm83_fetch_seq: PC owner and opcode/immediate fetch sequencer for SM83.
// FETCH_CB_PREFIX_EN: fetch the CB-extended opcode byte into operand[7:0].
module sm83_fetch_seq
    import sm83_fetch_pkg::*;
#(
    parameter int          ADDR_W    = 16,
    parameter logic [15:0] RESET_VEC = 16'h0000,
    parameter int          MAX_WAIT  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_val,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [7:0]        opcode,
    output logic [15:0]       operand,
    output logic [1:0]        operand_len,
    output logic              cb_prefix,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              bus_err
);

    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_VEC);
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
    localparam logic [7:0]        WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_t      state;
    logic [7:0]        wait_cnt;
    logic              imm_idx;
    logic              imm_last;
    logic [1:0]        dec_len;
    logic              dec_cb;
    logic [ADDR_W-1:0] pc_inc;

    sm83_oplen_decode u_dec (
        .op    (mem_rdata),
        .len   (dec_len),
        .is_cb (dec_cb)
    );

    assign mem_addr = pc;
    assign pc_inc   = pc + PC_ONE;
    assign imm_last = ({1'b0, imm_idx} + 2'd1) == operand_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_RESET;
            pc          <= PC_RST;
            mem_rd      <= 1'b0;
            instr_valid <= 1'b0;
            bus_err     <= 1'b0;
            cb_prefix   <= 1'b0;
            opcode      <= 8'h00;
            operand     <= 16'h0000;
            operand_len <= LEN_0;
            instr_pc    <= '0;
            wait_cnt    <= 8'd0;
            imm_idx     <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins over any in-flight ack or pending instruction.
            state       <= S_FETCH_OP;
            pc          <= pc_load_val;
            mem_rd      <= 1'b1;
            instr_valid <= 1'b0;
            bus_err     <= 1'b0;
            wait_cnt    <= 8'd0;
            imm_idx     <= 1'b0;
        end else begin
            unique case (state)
                S_RESET: begin
                    state    <= S_FETCH_OP;
                    mem_rd   <= 1'b1;
                    wait_cnt <= 8'd0;
                end
                S_FETCH_OP: begin
                    if (mem_ack) begin
                        opcode      <= mem_rdata;
                        instr_pc    <= pc;
                        pc          <= pc_inc;
                        operand     <= 16'h0000;
                        operand_len <= dec_len;
                        cb_prefix   <= dec_cb;
                        wait_cnt    <= 8'd0;
                        imm_idx     <= 1'b0;
                        if (dec_len == LEN_0) begin
                            state       <= S_HOLD;
                            mem_rd      <= 1'b0;
                            instr_valid <= 1'b1;
                        end else begin
                            state <= S_FETCH_IMM;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= S_ERR;
                        mem_rd  <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FETCH_IMM: begin
                    if (mem_ack) begin
                        if (imm_idx) operand[15:8] <= mem_rdata;
                        else         operand[7:0]  <= mem_rdata;
                        pc       <= pc_inc;
                        wait_cnt <= 8'd0;
                        imm_idx  <= 1'b1;
                        if (imm_last) begin
                            state       <= S_HOLD;
                            mem_rd      <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        state   <= S_ERR;
                        mem_rd  <= 1'b0;
                        bus_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (instr_ready) begin
                        state       <= S_FETCH_OP;
                        mem_rd      <= 1'b1;
                        instr_valid <= 1'b0;
                        wait_cnt    <= 8'd0;
                    end
                end
                S_ERR: begin
                    mem_rd <= 1'b0;
                end
                default: begin
                    state  <= S_RESET;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm83_fetch_seq.sv
// tb_sm83_fetch_seq: scoreboard bench for sm83_fetch_seq with a
// random-wait memory and an instruction-stream reference model.
module tb_sm83_fetch_seq;

`ifdef FETCH_CB_PREFIX_EN
    localparam bit CB_EN = 1'b1;
`else
    localparam bit CB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_load;
    logic [15:0] pc_load_val;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata = 8'h00;
    logic        mem_ack = 1'b0;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [15:0] operand;
    logic [1:0]  operand_len;
    logic        cb_prefix;
    logic [15:0] instr_pc;
    logic [15:0] pc;
    logic        bus_err;

    always #5 clk = ~clk;

    sm83_fetch_seq dut (
        .clk         (clk),
        .rst         (rst),
        .pc_load     (pc_load),
        .pc_load_val (pc_load_val),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .operand     (operand),
        .operand_len (operand_len),
        .cb_prefix   (cb_prefix),
        .instr_pc    (instr_pc),
        .pc          (pc),
        .bus_err     (bus_err)
    );

    typedef struct {
        logic [7:0]  op;
        logic [15:0] opnd;
        logic [1:0]  len;
        logic        cb;
        logic [15:0] ipc;
        logic [15:0] npc;
    } exp_t;

    logic [7:0] mem [0:65535];
    exp_t       q[$];
    int         vectors = 0;
    int         miscompares = 0;
    int         fixed_wait = 0;
    bit         ack_off = 1'b0;
    bit         prog_en = 1'b0;

    function automatic int ref_len(input logic [7:0] op);
        if (op inside {8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36,
                       8'h3E, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hC6,
                       8'hCE, 8'hD6, 8'hDE, 8'hE0, 8'hE6, 8'hE8, 8'hEE,
                       8'hF0, 8'hF6, 8'hF8, 8'hFE})
            return 1;
        if (op inside {8'h01, 8'h08, 8'h11, 8'h21, 8'h31, 8'hC2, 8'hC3,
                       8'hC4, 8'hCA, 8'hCC, 8'hCD, 8'hD2, 8'hD4, 8'hDA,
                       8'hDC, 8'hEA, 8'hFA})
            return 2;
        if (CB_EN && op == 8'hCB)
            return 1;
        return 0;
    endfunction

    // The instruction the core should see when fetching starts at a.
    function automatic exp_t predict(input logic [15:0] a);
        exp_t e;
        int   n;
        n      = ref_len(mem[a]);
        e.op   = mem[a];
        e.len  = 2'(n);
        e.ipc  = a;
        e.opnd = 16'h0000;
        if (n >= 1) e.opnd[7:0]  = mem[a + 16'd1];
        if (n == 2) e.opnd[15:8] = mem[a + 16'd2];
        e.cb   = CB_EN && (e.op == 8'hCB);
        e.npc  = a + 16'(1 + n);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] a);
        pc_load_val = a;
        pc_load     = 1'b1;
        step();
        pc_load     = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int n);
        n = 0;
        while (!instr_valid && n < lim) begin
            step();
            n++;
        end
        chk("wait_valid", 32'(instr_valid), 32'd1);
    endtask

    // Memory: holds each access for a chosen number of wait cycles.
    bit          in_acc = 1'b0;
    logic [15:0] acc_addr = 16'h0000;
    int          left = 0;

    always @(posedge clk) begin
        #1;
        if (mem_rd && !rst) begin
            if (!in_acc || mem_addr != acc_addr) begin
                in_acc   = 1'b1;
                acc_addr = mem_addr;
                if (ack_off)             left = 1000000;
                else if (fixed_wait >= 0) left = fixed_wait;
                else                      left = int'($urandom_range(0, 3));
            end
            if (left == 0 && !ack_off) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                in_acc    = 1'b0;
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
                if (left > 0) left--;
            end
        end else begin
            mem_ack   = 1'b0;
            in_acc    = 1'b0;
            mem_rdata = 8'($urandom);
        end
    end

    // Monitor: scores each accepted instruction and bus-side invariants.
    bit          prev_wait = 1'b0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_addr = 16'h0000;
    logic [42:0] snap = '0;
    logic [42:0] cur;
    int          idle = 0;
    exp_t        e;

    always @(negedge clk) begin
        if (rst) begin
            prev_wait = 1'b0;
            prev_hold = 1'b0;
            idle      = 0;
        end else begin
            cur = {opcode, operand, operand_len, instr_pc, cb_prefix};
            if (mem_rd)
                chk("addr_is_pc", 32'(mem_addr), 32'(pc));
            if (prev_wait && mem_rd)
                chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
            if (prev_hold)
                chk("hold_stable", 32'(instr_valid && cur == snap), 32'd1);
            if (instr_valid && instr_ready) begin
                idle = 0;
                if (q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_instr: got opcode %h, required none",
                             opcode);
                end else begin
                    e = q.pop_front();
                    chk("opcode", 32'(opcode), 32'(e.op));
                    chk("operand", 32'(operand), 32'(e.opnd));
                    chk("operand_len", 32'(operand_len), 32'(e.len));
                    chk("instr_pc", 32'(instr_pc), 32'(e.ipc));
                    chk("cb_prefix", 32'(cb_prefix), 32'(e.cb));
                    chk("pc_after", 32'(pc), 32'(e.npc));
                    if (!pc_load) q.push_back(predict(e.npc));
                end
            end else begin
                idle++;
            end
            if (pc_load) begin
                q.delete();
                q.push_back(predict(pc_load_val));
                idle = 0;
            end
            if (prog_en && idle == 300) begin
                vectors++;
                miscompares++;
                $display("FAIL progress_timeout: got %0d idle cycles, required < 300",
                         idle);
            end
            prev_wait = mem_rd && !mem_ack && !pc_load;
            prev_hold = instr_valid && !instr_ready && !pc_load;
            prev_addr = mem_addr;
            snap      = cur;
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst         = 1'b1;
        pc_load     = 1'b0;
        pc_load_val = 16'h0000;
        instr_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0000] = 8'h00;
        mem[16'h0001] = 8'h00;
        mem[16'h0010] = 8'h01;
        mem[16'h0011] = 8'h34;
        mem[16'h0012] = 8'h12;
        mem[16'h0020] = 8'h3E;
        mem[16'h0021] = 8'h7F;
        mem[16'h0050] = 8'hC3;
        mem[16'h0060] = 8'hCB;
        mem[16'h0061] = 8'h37;
        q.push_back(predict(16'h0000));

        repeat (2) step();
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_bus_err", 32'(bus_err), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_operand", 32'(operand), 32'd0);
        chk("rst_len", 32'(operand_len), 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_cb", 32'(cb_prefix), 32'd0);

        rst = 1'b0;
        step();
        chk("t1_rd0", 32'(mem_rd), 32'd1);
        chk("t1_addr0", 32'(mem_addr), 32'h0000);
        step();
        chk("t1_valid", 32'(instr_valid), 32'd1);
        chk("t1_addr1", 32'(mem_addr), 32'h0001);
        step();
        chk("t1_rd1", 32'(mem_rd), 32'd1);
        chk("t1_next_addr", 32'(mem_addr), 32'h0001);

        jump(16'h0010);
        wait_valid(20, n);
        chk("t2_latency", 32'(n), 32'd3);
        chk("t2_operand", 32'(operand), 32'h1234);
        chk("t2_pc", 32'(pc), 32'h0013);

        fixed_wait = 2;
        jump(16'h0020);
        wait_valid(30, n);
        chk("t3_latency", 32'(n), 32'd6);
        chk("t3_operand", 32'(operand), 32'h007F);
        chk("t3_len", 32'(operand_len), 32'd1);
        fixed_wait = 0;

        ack_off = 1'b1;
        jump(16'h0040);
        n = 0;
        while (mem_rd && n < 40) begin
            n++;
            step();
        end
        chk("t4_rd_cycles", 32'(n), 32'd15);
        chk("t4_bus_err", 32'(bus_err), 32'd1);
        chk("t4_mem_rd", 32'(mem_rd), 32'd0);
        chk("t4_pc", 32'(pc), 32'h0040);
        repeat (3) step();
        chk("t4_sticky", 32'(bus_err), 32'd1);
        ack_off = 1'b0;
        jump(16'h0100);
        chk("t4_clear", 32'(bus_err), 32'd0);
        chk("t4_addr", 32'(mem_addr), 32'h0100);
        chk("t4_rd", 32'(mem_rd), 32'd1);

        jump(16'h0050);
        step();
        pc_load_val = 16'h0200;
        pc_load     = 1'b1;
        step();
        pc_load     = 1'b0;
        chk("t5_addr", 32'(mem_addr), 32'h0200);
        chk("t5_no_valid", 32'(instr_valid), 32'd0);
        instr_ready = 1'b0;
        wait_valid(20, n);
        repeat (10) step();
        chk("t5_held", 32'(instr_valid), 32'd1);
        chk("t5_held_pc", 32'(instr_pc), 32'h0200);
        instr_ready = 1'b1;

        mem[16'hFFFF] = 8'h21;
        mem[16'h0000] = 8'hAA;
        mem[16'h0001] = 8'hBB;
        jump(16'hFFFF);
        wait_valid(20, n);
        chk("t6_operand", 32'(operand), 32'hBBAA);
        chk("t6_instr_pc", 32'(instr_pc), 32'hFFFF);
        chk("t6_pc", 32'(pc), 32'h0002);

        jump(16'h0060);
        wait_valid(20, n);
        chk("cb_flag", 32'(cb_prefix), 32'(CB_EN));
        chk("cb_operand", 32'(operand), CB_EN ? 32'h0037 : 32'h0000);
        chk("cb_len", 32'(operand_len), CB_EN ? 32'd1 : 32'd0);

        fixed_wait = -1;
        prog_en    = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            instr_ready = ($urandom_range(0, 9) < 7);
            pc_load     = ($urandom_range(0, 49) == 0);
            pc_load_val = 16'($urandom);
            step();
        end
        pc_load     = 1'b0;
        prog_en     = 1'b0;
        instr_ready = 1'b1;

        n = 0;
        while (!mem_rd && n < 20) begin
            step();
            n++;
        end
        rst = 1'b1;
        #1;
        chk("async_rst_rd", 32'(mem_rd), 32'd0);
        chk("async_rst_pc", 32'(pc), 32'h0000);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        q.delete();
        q.push_back(predict(16'h0000));
        step();
        rst = 1'b0;
        repeat (60) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
